dac7611_rx: RTL and testbench
=============================

# dac7611_rx

Serial-frame receiver for the DAC7611 three-wire load interface (CLK, SDI, LD). It samples the pin-level signals driven by our DAC transmitter with a faster system clock and reconstructs each 12-bit word. It reports every good frame and flags malformed ones. It sits on the FPGA fabric as a loopback and monitor block, tapping the same nets that go to the DAC.

## Interface
- `DATA_W`, default 12: bits per frame. MSB is shifted first.
- `SYNC_STAGES`, default 2: flip-flop stages on each pin input. Must be 2 or more.
- `clk` input 1: system clock. Must be at least 4× the pin CLK rate.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: high enables the block.
- `CLK_3` input 1: serial clock pin. Data is captured on its rising edge.
- `SDI_4` input 1: serial data pin.
- `LD_5` input 1: load pin. High frames a transfer; the falling edge ends the frame.
- `dac_word` output DATA_W: last correctly received word.
- `word_valid` output 1: one-`clk` pulse when `dac_word` updates.
- `frame_err` output 1: one-`clk` pulse when a frame ends with a bit count other than DATA_W.
- `frame_cnt` output 8: count of good frames. Wraps 255→0.
- `busy` output 1: high while in SHIFT.

## Operation
- **Input synchronisers.** All three pins pass through SYNC_STAGES flops. One further registered copy of each synchronised pin feeds the edge detectors.
- **Edge detection.** Edges are taken from the synchronised signals:
  - `clk_rise` = sync CLK is 1 and its previous value was 0.
  - `ld_rise` and `ld_fall` are formed the same way from LD.
  - SDI is sampled from its synchronised copy in the same cycle as `clk_rise`. SDI therefore sees the same delay as CLK.
- **State machine, IDLE.** Entered on reset or when `enable` is low.
  - On `ld_rise`: clear the shift register and bit counter, then go to SHIFT.
  - `clk_rise` in IDLE is ignored, with no error.
- **State machine, SHIFT.**
  - Each `clk_rise`: shift register ← {shift[DATA_W-2:0], sdi}. The bit counter increments and saturates at 15 (4 bits).
  - On `ld_fall`, the frame is evaluated:
    - Counter equal to DATA_W: `dac_word` ← shift register, pulse `word_valid`, increment `frame_cnt`.
    - Any other count: pulse `frame_err` and leave `dac_word` unchanged.
  - After evaluation, return to IDLE.
- **Over-length frames.** The shift register keeps the last DATA_W bits, but the counter exceeds DATA_W, so the frame is an error.
- **Simultaneous `clk_rise` and `ld_fall` in one cycle.** The shift and count are applied first. Evaluation uses the updated count and register.
- **`ld_rise` while already in SHIFT.** This is impossible without an intervening fall and needs no handling.
- **`enable` low.**
  - State goes to IDLE; the shift register and counter clear.
  - `dac_word` and `frame_cnt` hold.
  - No pulses are produced.
  - The synchronisers keep running.
- **Reset values.**
  - `dac_word` = 0, `word_valid` = 0, `frame_err` = 0, `frame_cnt` = 0, `busy` = 0.
  - State is IDLE.
  - Synchroniser flops are 0.
- **Reset mid-frame.** The partial frame is discarded. No pulse is produced on release. A subsequent LD fall without a preceding rise is ignored.

## Timing
- **Pin-to-edge latency.** A pin transition produces its edge strobe SYNC_STAGES+1 `clk` cycles later: 3 cycles at the default.
- **Result latency.** `word_valid` or `frame_err` is registered. It is asserted on the `clk` edge after the cycle in which `ld_fall` is detected. `dac_word` becomes valid in the same cycle as `word_valid`.
- **Input constraints.** Each CLK high or low phase must last 2 or more `clk` cycles. SDI must be stable for 1 or more `clk` cycles either side of the CLK rising edge. The transmitter's 4× pattern (two cycles low, two high, SDI held 4 cycles) meets both.
- **Back-to-back frames.** LD low for one pin period (one `clk` cycle after sync) is sufficient. IDLE accepts `ld_rise` in the cycle after evaluation.
- **Pulse widths.** `word_valid` and `frame_err` are exactly one cycle. They are never asserted together.

## Test plan
- **Nominal frame.** Drive a 4×-pattern frame of 0xDFF (bits 1,1,0,1,1,1,1,1,1,1,1,1) with LD high around 12 CLK pulses. Required: `dac_word` = 0xDFF, one `word_valid` pulse, `frame_cnt` = 1, `busy` falling with the pulse.
- **Short and long frames.** Send 11 CLK pulses of 0xFFF, then 13 pulses of 0x000. Required: two `frame_err` pulses, `dac_word` still 0xDFF, `frame_cnt` unchanged.
- **Repeated frames with wrap.** Send 256 back-to-back good frames alternating 0x000 and 0xFFF. Required: 256 `word_valid` pulses, `frame_cnt` wraps to 0, final `dac_word` = 0xFFF.
- **Coincident last edge.** Make the 12th CLK rise and the LD fall arrive in the same synchronised cycle with word 0x801. Required: `word_valid`, `dac_word` = 0x801.
- **Reset mid-frame.** Assert `rst` after 6 bits. Release, then drop LD. Required: all outputs 0, no pulses. The next full frame of 0x5A5 is received correctly.
- **Enable low mid-frame.** Drop `enable` after 6 bits and toggle CLK 6 more times. Required: no pulses and `dac_word` holds. After re-enable, a new frame of 0x123 is received.

Source files
------------

// File: rtl/dac7611_rx.sv
// Receiver for the DAC7611 three-wire load interface (CLK, SDI, LD).
// Oversamples the pins on the system clock and reconstructs each serial word.
module dac7611_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              CLK_3,
    input  logic              SDI_4,
    input  logic              LD_5,
    output logic [DATA_W-1:0] dac_word,
    output logic              word_valid,
    output logic              frame_err,
    output logic [7:0]        frame_cnt,
    output logic              busy
);
    localparam int NPINS   = 3;
    localparam int PIN_CLK = 0;
    localparam int PIN_SDI = 1;
    localparam int PIN_LD  = 2;
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [NPINS-1:0] pins;
    logic [NPINS-1:0] pin_sync;

    assign pins[PIN_CLK] = CLK_3;
    assign pins[PIN_SDI] = SDI_4;
    assign pins[PIN_LD]  = LD_5;

    genvar gi;
    generate
        for (gi = 0; gi < NPINS; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
                end
            end
            assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic                   prev_clk_reg;
    logic                   prev_ld_reg;
    logic [SYNC_STAGES:0]   prime_reg;
    logic                   primed;
    logic                   clk_rise;
    logic                   ld_rise;
    logic                   ld_fall;
    logic                   sdi;

    // Edges are masked until the chains have filled with real pin levels, so a
    // pin that was already high across reset release does not look like a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_clk_reg <= 1'b0;
            prev_ld_reg  <= 1'b0;
            prime_reg    <= '0;
        end else begin
            prev_clk_reg <= pin_sync[PIN_CLK];
            prev_ld_reg  <= pin_sync[PIN_LD];
            prime_reg    <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign primed   = prime_reg[SYNC_STAGES];
    assign clk_rise = primed &  pin_sync[PIN_CLK] & ~prev_clk_reg;
    assign ld_rise  = primed &  pin_sync[PIN_LD]  & ~prev_ld_reg;
    assign ld_fall  = primed & ~pin_sync[PIN_LD]  &  prev_ld_reg;
    assign sdi      = pin_sync[PIN_SDI];

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] dac_word_reg;
    logic              word_valid_reg;
    logic              frame_err_reg;
    logic [7:0]        frame_cnt_reg;
    logic              busy_reg;

    // The shift/count update is computed ahead so a clock edge that coincides
    // with the LD fall is counted before the frame is judged.
    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        if (clk_rise) begin
            shift_next = {shift_reg[DATA_W-2:0], sdi};
            if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            cnt_reg        <= '0;
            dac_word_reg   <= '0;
            word_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            frame_cnt_reg  <= '0;
            busy_reg       <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (!enable) begin
                state_reg <= IDLE;
                shift_reg <= '0;
                cnt_reg   <= '0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (ld_rise) begin
                            shift_reg <= '0;
                            cnt_reg   <= '0;
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        shift_reg <= shift_next;
                        cnt_reg   <= cnt_next;
                        if (ld_fall) begin
                            if (cnt_next == CNT_FULL) begin
                                dac_word_reg   <= shift_next;
                                word_valid_reg <= 1'b1;
                                frame_cnt_reg  <= frame_cnt_reg + 8'd1;
                            end else begin
                                frame_err_reg  <= 1'b1;
                            end
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dac_word   = dac_word_reg;
    assign word_valid = word_valid_reg;
    assign frame_err  = frame_err_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_dac7611_rx.sv
// Scoreboard bench for dac7611_rx: frames are driven at pin level, the expected
// frame outcome is queued, and a monitor checks each result pulse against it.
module tb_dac7611_rx;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         CLK_3;
    logic         SDI_4;
    logic         LD_5;
    logic [W-1:0] dac_word;
    logic         word_valid;
    logic         frame_err;
    logic [7:0]   frame_cnt;
    logic         busy;

    dac7611_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .CLK_3      (CLK_3),
        .SDI_4      (SDI_4),
        .LD_5       (LD_5),
        .dac_word   (dac_word),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_err;
        logic [W-1:0] word;
        logic [7:0]   cnt;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] model_word;
    logic [7:0]   model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: a frame of exactly W clock pulses delivers its bits as the word,
    // any other length is an error and the word/count stay put.
    task automatic expect_frame(input int n, input logic [31:0] val);
        exp_t e;
        if (n == W) begin
            model_word = val[W-1:0];
            model_cnt  = model_cnt + 8'd1;
            e.is_err   = 1'b0;
        end else begin
            e.is_err   = 1'b1;
        end
        e.word = model_word;
        e.cnt  = model_cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input bit drop_ld);
        SDI_4 = b;
        CLK_3 = 1'b0;
        tick(2);
        CLK_3 = 1'b1;
        if (drop_ld) LD_5 = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input int n, input logic [31:0] val, input bit coinc, input int gap);
        LD_5 = 1'b1;
        tick(2);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(val[i], coinc && (i == 0));
            if (i == n - 3) check("busy_mid_frame", busy, 1);
        end
        LD_5 = 1'b0;
        expect_frame(n, val);
        CLK_3 = 1'b0;
        tick(gap);
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (word_valid || frame_err) begin
                check("pulse_exclusive", {31'd0, word_valid & frame_err}, 0);
                check("busy_with_pulse", busy, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse actual valid=%0b err=%0b required none",
                             word_valid, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_err", frame_err, e.is_err);
                    check("dac_word", dac_word, e.word);
                    check("frame_cnt", frame_cnt, e.cnt);
                    $display("txn t=%0t %s word=%03h cnt=%0d", $time,
                             frame_err ? "err  " : "valid", dac_word, frame_cnt);
                end
            end
        end
    end

    initial begin
        logic [31:0] rv;
        rst        = 1'b1;
        enable     = 1'b1;
        CLK_3      = 1'b0;
        SDI_4      = 1'b0;
        LD_5       = 1'b0;
        model_word = '0;
        model_cnt  = '0;
        tick(3);
        check("rst_dac_word", dac_word, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(6);

        // Nominal frame
        send_frame(12, 32'hDFF, 1'b0, 4);
        tick(6);
        check("nominal_word", dac_word, 12'hDFF);
        check("nominal_cnt", frame_cnt, 1);

        // Short and long frames, plus one long enough that a wrapping counter would land on 12
        send_frame(11, 32'hFFF, 1'b0, 4);
        send_frame(13, 32'h000, 1'b0, 4);
        send_frame(28, 32'h0ABCDEF, 1'b0, 4);
        tick(6);
        check("badlen_word_hold", dac_word, 12'hDFF);
        check("badlen_cnt_hold", frame_cnt, 1);

        // Last clock rise coincident with LD fall
        send_frame(12, 32'h801, 1'b1, 4);
        tick(6);
        check("coinc_word", dac_word, 12'h801);

        // Reset mid-frame with LD still high across release
        LD_5 = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        CLK_3 = 1'b0;
        rst = 1'b1;
        model_word = '0;
        model_cnt  = '0;
        tick(3);
        rst = 1'b0;
        tick(8);
        LD_5 = 1'b0;
        tick(10);
        check("midrst_dac_word", dac_word, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_busy", busy, 0);
        send_frame(12, 32'h5A5, 1'b0, 4);
        tick(6);
        check("after_rst_word", dac_word, 12'h5A5);

        // Enable dropped mid-frame
        LD_5 = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        CLK_3 = 1'b0;
        LD_5  = 1'b0;
        tick(6);
        check("dis_word_hold", dac_word, model_word);
        check("dis_cnt_hold", frame_cnt, model_cnt);
        check("dis_busy", busy, 0);
        enable = 1'b1;
        tick(4);
        send_frame(12, 32'h123, 1'b0, 4);
        tick(6);
        check("reenable_word", dac_word, 12'h123);

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            int n;
            n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : W;
            rv = $urandom;
            send_frame(n, rv, 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
        end
        tick(6);
        check("random_word", dac_word, model_word);

        // 256 back-to-back good frames, counter wraps
        for (int k = 0; k < 256; k++) begin
            send_frame(12, (k % 2 == 1) ? 32'hFFF : 32'h000, 1'b0, 1);
        end
        tick(8);
        check("wrap_cnt", frame_cnt, model_cnt);
        check("wrap_word", dac_word, 12'hFFF);

        tick(20);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
